spi_slave_out: RTL and testbench
================================

Name: spi_slave_out

Overview:
- SPI slave transmitter. Shifts a BITS-wide word out on MISO, MSB first, while the PID core's SPI input port shifts its configuration word in.
- SCK and CS are oversampled in the clk domain.
- SPI mode 1 (CPOL=0, CPHA=1): the slave drives MISO on SCK rising edges; the master samples on SCK falling edges.
- The PID core loads status/telemetry words through a one-entry valid/ready holding register, so one word can be queued while another is being shifted.

Parameters:
- BITS, 32, frame length in bits (minimum 2).
- IDLE_WORD, 32'h00000000, word transmitted when a frame starts with the holding register empty.

Ports:
- clk  in  1  system clock; must run at least 8x SCK.
- reset  in  1  synchronous, active-high; clock clk.
- cs  in  1  SPI chip select, active-low, asynchronous to clk.
- sck  in  1  SPI clock, asynchronous to clk.
- load_data  in  BITS  word to transmit.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  holding register empty; a load is accepted when load_valid && load_ready.
- miso  out  1  serial data out.
- miso_oe  out  1  output enable for the MISO pad; high while a frame is active.
- done  out  1  one-cycle pulse when a complete BITS-bit frame has been sampled.
- underrun  out  1  one-cycle pulse when a frame starts with the holding register empty.

Behaviour:
- Synchronizers: cs and sck each pass through 2 flops (s1, s2), followed by a third edge-detect flop (s3).
  - rise = sck_s2 & !sck_s3; fall = !sck_s2 & sck_s3.
  - cs_start = !cs_s2 & cs_s3; cs_end = cs_s2.
- Reset values: load_ready=1, miso=0, miso_oe=0, done=0, underrun=0, state=IDLE, holding register empty, bit count 0, all synchronizer flops=1 (CS idle).
- Holding register:
  - A load is accepted on any cycle with load_valid && load_ready; the register becomes full and load_ready=0 from the next cycle.
  - load_ready is a registered function of the full flag only, so it is never combinationally dependent on load_valid.
- State IDLE:
  - miso_oe=0, miso=0.
  - On cs_start: shift register <= holding if full, else IDLE_WORD.
  - If the holding register was full: clear full (load_ready=1 next cycle).
  - If it was empty: pulse underrun.
  - Set bit count=0, first=1, miso_oe=1, miso=MSB of the loaded word. Go to SHIFT.
- State SHIFT:
  - On rise with first=1: clear first; miso keeps the MSB.
  - On rise with first=0: shift left by 1; miso=new MSB.
  - On fall: bit count +1. When the count reaches BITS: pulse done, go to DONE.
- State DONE:
  - miso=0, miso_oe stays 1; further SCK edges are ignored.
- Chip-select end:
  - cs_end in SHIFT or DONE returns to IDLE the same cycle; miso_oe=0 next cycle.
  - A frame aborted in SHIFT produces no done pulse. Its word is discarded, not re-queued.
- Simultaneous events:
  - A load accepted in the same cycle as cs_start with the register empty: the frame sends IDLE_WORD and pulses underrun; the loaded word stays queued for the next frame.
  - Loads during SHIFT/DONE are accepted normally (double buffering).
- Latency: an SCK or CS pin transition is reflected on miso/miso_oe on the 3rd rising clk edge after the transition.
- Reset mid-frame: immediate return to the reset values; the queued word is discarded.
- Bit counter width: $clog2(BITS+1). It must not wrap inside a frame.

Optional Feature:
- SPI_OUT_INVERT_EN
  - Defined: the miso pin carries the logical inverse of the data bit, matching the inverted MOSI line convention of the board's SPI input port. When miso_oe=0, miso is driven 1 (inverse of idle 0).
  - Undefined: miso carries true data; it is 0 when idle.
  - No other behaviour changes.

Test Plan:
- Frame: reset, load 32'hDEADBEEF, then a 32-clock SPI mode 1 frame at clk/8 -> master samples 32'hDEADBEEF; done pulses exactly once after the 32nd falling edge; load_ready=1 from the cycle after cs_start; underrun stays 0.
- Underrun: no load, one frame -> master samples 32'h00000000; underrun pulses once at frame start; done pulses at the end.
- Back-to-back: load 32'h12345678, start a frame, load 32'hCAFEF00D mid-frame, run 2 frames -> the master receives 12345678 then CAFEF00D; load_ready=0 between the second load and the second cs_start.
- Abort: load 32'hA5000000, deassert CS after 8 SCK cycles -> first byte sampled 8'hA5; no done pulse; miso_oe=0 within 3 clk of CS high; the next frame sends IDLE_WORD and pulses underrun.
- Overclock: 40 SCK cycles in one frame with 32'hFFFFFFFF loaded -> 32 ones then 8 zeros sampled; done pulses only once.
- Reset mid-frame: assert reset after 10 bits -> miso=0, miso_oe=0, load_ready=1 the next cycle; the following frame underruns.

Source files
------------

// File: rtl/spi_slave_out_if.sv
// SPI slave transmitter bus: SPI pins plus the one-entry load channel.
// Latency: not applicable (signal bundle only).
// Backpressure: load_ready from the slave throttles load_valid from the core.
interface spi_slave_out_if #(
  parameter int BITS = 32
);
  logic            cs;
  logic            sck;
  logic [BITS-1:0] load_data;
  logic            load_valid;
  logic            load_ready;
  logic            miso;
  logic            miso_oe;
  logic            done;
  logic            underrun;

  // Transmitter side: samples the pins and the load channel, drives MISO and status.
  modport slave (
    input  cs, sck, load_data, load_valid,
    output load_ready, miso, miso_oe, done, underrun
  );

  // Driving side: SPI master pins plus the core that supplies words.
  modport master (
    output cs, sck, load_data, load_valid,
    input  load_ready, miso, miso_oe, done, underrun
  );
endinterface

// File: rtl/spi_slave_out.sv
// SPI mode-1 slave transmitter, MSB first, one-entry holding register; optional SPI_OUT_INVERT_EN inverts the MISO pin.
// Latency: an SCK/CS pin transition shows on miso/miso_oe at the 3rd rising clk edge after it.
// Backpressure: load_ready = holding register empty; a second word waits until the next frame start frees it.
module spi_slave_out #(
  parameter int              BITS      = 32,
  parameter logic [BITS-1:0] IDLE_WORD = '0
) (
  input logic           clk,
  input logic           reset,
  spi_slave_out_if.slave bus
);

  localparam int CW = $clog2(BITS + 1);

`ifdef SPI_OUT_INVERT_EN
  localparam logic MISO_INV = 1'b1;
`else
  localparam logic MISO_INV = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Synchronizer chains: [0]=s1, [1]=s2, [2]=s3 (edge-detect history).
  logic [2:0] cs_sync_q, cs_sync_d;
  logic [2:0] sck_sync_q, sck_sync_d;

  state_t          state_q, state_d;
  logic            full_q, full_d;
  logic [BITS-1:0] hold_q, hold_d;
  logic [BITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            first_q, first_d;
  logic            miso_q, miso_d;
  logic            oe_q, oe_d;
  logic            done_q, done_d;
  logic            underrun_q, underrun_d;

  logic sck_rise, sck_fall, cs_start, cs_end;

  // Shift the raw pins into the synchronizer chains.
  always_comb begin
    cs_sync_d  = {cs_sync_q[1:0], bus.cs};
    sck_sync_d = {sck_sync_q[1:0], bus.sck};
  end

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_start = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_end   = cs_sync_q[1];

  // Next-state, holding register and output logic.
  always_comb begin
    state_d    = state_q;
    full_d     = full_q;
    hold_d     = hold_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;

    // Loads are only taken while empty, so they never collide with the
    // frame-start consume below (which needs full_q set). A load in the
    // cs_start cycle with an empty register stays queued for the next frame.
    if (bus.load_valid && !full_q) begin
      full_d = 1'b1;
      hold_d = bus.load_data;
    end

    case (state_q)
      IDLE: begin
        oe_d   = 1'b0;
        miso_d = 1'b0;
        if (cs_start) begin
          if (full_q) begin
            shreg_d = hold_q;
            full_d  = 1'b0;
          end else begin
            shreg_d    = IDLE_WORD;
            underrun_d = 1'b1;
          end
          cnt_d   = '0;
          first_d = 1'b1;
          oe_d    = 1'b1;
          miso_d  = shreg_d[BITS-1];
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cs_end) begin
          // Abort: the partially sent word is dropped.
          state_d = IDLE;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
        end else if (sck_rise) begin
          // The MSB is already on the pin from frame start; the first rise holds it.
          if (first_q) begin
            first_d = 1'b0;
          end else begin
            shreg_d = {shreg_q[BITS-2:0], 1'b0};
          end
          miso_d = shreg_d[BITS-1];
        end else if (sck_fall) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(BITS)) begin
            done_d  = 1'b1;
            miso_d  = 1'b0;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // Extra SCK edges past the frame length are ignored.
        miso_d = 1'b0;
        if (cs_end) begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        oe_d    = 1'b0;
        miso_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset (CS idle high in the syncs).
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q  <= 3'b111;
      sck_sync_q <= 3'b111;
      state_q    <= IDLE;
      full_q     <= 1'b0;
      hold_q     <= '0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cs_sync_q  <= cs_sync_d;
      sck_sync_q <= sck_sync_d;
      state_q    <= state_d;
      full_q     <= full_d;
      hold_q     <= hold_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.load_ready = ~full_q;
  assign bus.miso       = miso_q ^ MISO_INV;
  assign bus.miso_oe    = oe_q;
  assign bus.done       = done_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_spi_slave_out.sv
// Bench for spi_slave_out: table vectors, hand-written corner sequences, random frames.
// Latency: SCK half period is 4 clk so MISO settles before each master sample.
// Backpressure: loads are offered until load_ready, bounded to 20 cycles.
module tb_spi_slave_out;

  localparam int          BITS   = 32;
  localparam logic [31:0] IDLE_W = 32'h0000_0000;
`ifdef SPI_OUT_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_slave_out_if #(.BITS(BITS)) bus ();

  spi_slave_out #(.BITS(BITS), .IDLE_WORD(IDLE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int und_cnt = 0;

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.underrun) und_cnt++;
  end

  typedef struct {
    logic [31:0] word;
    bit          preload;
    int          nb;
    logic [63:0] exp_got;
    int          exp_done;
    int          exp_und;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.load_data  = w;
    bus.load_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.load_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1 bus.load_valid = 1'b0;
    check("load_accepted", 64'(ok), 64'd1);
  endtask

  // Drop CS; optionally present a load exactly on the frame-start edge.
  task automatic cs_begin(input bit sim_ld, input logic [31:0] sim_w);
    @(negedge clk);
    bus.cs = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (sim_ld) begin
      bus.load_data  = sim_w;
      bus.load_valid = 1'b1;
    end
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
    @(negedge clk);
  endtask

  // Mode-1 master: raise SCK, wait half a period, sample MISO, drop SCK.
  task automatic clock_bits(input int nb, output logic [63:0] got);
    got = '0;
    for (int i = 0; i < nb; i++) begin
      bus.sck = 1'b1;
      repeat (4) @(negedge clk);
      if (i == 0) check("oe_active", 64'(bus.miso_oe), 64'd1);
      got = {got[62:0], bus.miso ^ INV};
      bus.sck = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic cs_finish();
    bus.cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("oe_off_3clk", 64'(bus.miso_oe), 64'd0);
    check("miso_idle", 64'(bus.miso), 64'(INV));
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(input int nb, input bit sim_ld, input logic [31:0] sim_w,
                       input bit mid_ld, input logic [31:0] mid_w, input int mid_dly,
                       output logic [63:0] got, output int dn, output int un,
                       output logic rdy_start, output logic rdy_end);
    int d0, u0;
    logic [63:0] g;
    d0 = done_cnt;
    u0 = und_cnt;
    cs_begin(sim_ld, sim_w);
    rdy_start = bus.load_ready;
    fork
      clock_bits(nb, g);
      begin
        if (mid_ld) begin
          repeat (mid_dly) @(negedge clk);
          do_load(mid_w);
        end
      end
    join
    rdy_end = bus.load_ready;
    cs_finish();
    got = g;
    dn  = done_cnt - d0;
    un  = und_cnt - u0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset  = 1'b1;
    bus.cs = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  logic [63:0] got, exp;
  int          dn, un;
  logic        rs, re;
  logic [31:0] pend[$];
  logic [31:0] sent, w, mw;
  bit          exp_un, mid;
  int          nb, d0, u0;

  initial begin
    bus.cs         = 1'b1;
    bus.sck        = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;

    vecs[0] = '{32'hDEADBEEF, 1'b1, 32, 64'h0000_0000_DEAD_BEEF, 1, 0};
    vecs[1] = '{32'h0,        1'b0, 32, 64'h0,                   1, 1};
    vecs[2] = '{32'hFFFFFFFF, 1'b1, 40, 64'h0000_00FF_FFFF_FF00, 1, 0};
    vecs[3] = '{32'hA5000000, 1'b1, 8,  64'h0000_0000_0000_00A5, 0, 0};
    vecs[4] = '{32'h0,        1'b0, 32, 64'h0,                   1, 1};

    // Reset state.
    repeat (4) @(negedge clk);
    check("rst_miso", 64'(bus.miso), 64'(INV));
    check("rst_oe", 64'(bus.miso_oe), 64'd0);
    check("rst_ready", 64'(bus.load_ready), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_underrun", 64'(bus.underrun), 64'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_oe", 64'(bus.miso_oe), 64'd0);
    check("idle_ready", 64'(bus.load_ready), 64'd1);

    // Table: normal, underrun, overclock, abort, post-abort underrun.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].preload) do_load(vecs[v].word);
      frame(vecs[v].nb, 1'b0, '0, 1'b0, '0, 0, got, dn, un, rs, re);
      check($sformatf("vec%0d_data", v), got, vecs[v].exp_got);
      check($sformatf("vec%0d_done", v), 64'(dn), 64'(vecs[v].exp_done));
      check($sformatf("vec%0d_underrun", v), 64'(un), 64'(vecs[v].exp_und));
      check($sformatf("vec%0d_ready_after_start", v), 64'(rs), 64'd1);
    end

    // Back-to-back with a mid-frame load.
    do_load(32'h12345678);
    frame(32, 1'b0, '0, 1'b1, 32'hCAFEF00D, 60, got, dn, un, rs, re);
    check("b2b1_data", got, 64'h1234_5678);
    check("b2b1_ready_start", 64'(rs), 64'd1);
    check("b2b1_ready_end", 64'(re), 64'd0);
    check("b2b1_done", 64'(dn), 64'd1);
    check("b2b_ready_between", 64'(bus.load_ready), 64'd0);
    frame(32, 1'b0, '0, 1'b0, '0, 0, got, dn, un, rs, re);
    check("b2b2_data", got, 64'hCAFE_F00D);
    check("b2b2_underrun", 64'(un), 64'd0);
    check("b2b2_ready_start", 64'(rs), 64'd1);

    // Load accepted on the frame-start edge while empty.
    frame(32, 1'b1, 32'h0BADF00D, 1'b0, '0, 0, got, dn, un, rs, re);
    check("sim_data", got, 64'(IDLE_W));
    check("sim_underrun", 64'(un), 64'd1);
    check("sim_ready_start", 64'(rs), 64'd0);
    frame(32, 1'b0, '0, 1'b0, '0, 0, got, dn, un, rs, re);
    check("sim_next_data", got, 64'h0BAD_F00D);
    check("sim_next_underrun", 64'(un), 64'd0);

    // Reset in the middle of a frame with a word queued.
    w  = 32'h11112222;
    d0 = done_cnt;
    do_load(w);
    cs_begin(1'b0, '0);
    do_load(32'h33334444);
    clock_bits(10, got);
    check("rstmid_bits", got, 64'(w >> 22));
    @(negedge clk);
    reset  = 1'b1;
    bus.cs = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_miso", 64'(bus.miso), 64'(INV));
    check("rstmid_oe", 64'(bus.miso_oe), 64'd0);
    check("rstmid_ready", 64'(bus.load_ready), 64'd1);
    check("rstmid_no_done", 64'(done_cnt - d0), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    frame(32, 1'b0, '0, 1'b0, '0, 0, got, dn, un, rs, re);
    check("rstmid_next_data", got, 64'(IDLE_W));
    check("rstmid_next_underrun", 64'(un), 64'd1);

    // Random frames against a queue-based reference model.
    apply_reset();
    pend.delete();
    for (int r = 0; r < 14; r++) begin
      nb = $urandom_range(1, 40);
      if (pend.size() == 0 && ($urandom % 2 == 1)) begin
        w = $urandom;
        do_load(w);
        pend.push_back(w);
      end
      check($sformatf("rnd%0d_ready_pre", r), 64'(bus.load_ready), 64'(pend.size() == 0));
      exp_un = (pend.size() == 0);
      sent   = exp_un ? IDLE_W : pend.pop_front();
      mid    = (nb >= 4) && ($urandom % 2 == 1);
      mw     = $urandom;
      if (mid) pend.push_back(mw);
      frame(nb, 1'b0, '0, mid, mw, $urandom_range(0, nb * 8 - 4), got, dn, un, rs, re);
      exp = '0;
      for (int k = 0; k < nb; k++) exp = {exp[62:0], (k < 32) ? sent[31 - k] : 1'b0};
      check($sformatf("rnd%0d_data", r), got, exp);
      check($sformatf("rnd%0d_done", r), 64'(dn), 64'(nb >= 32));
      check($sformatf("rnd%0d_underrun", r), 64'(un), 64'(exp_un));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
